seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive end of the multiplexed 7-segment display interface: samples segment/digit-select lines
//  as driven by the display driver, filters them until stable, maps each glyph back to a hex nibble
//  and assembles a full NDIG-digit frame. Used for on-chip loopback self-check and as a bench monitor.
// PARAMETERS
//  NDIG        4  number of multiplexed digits (one-hot select width), 1..8
//  STABLE_CYC  4  consecutive identical samples required before a digit is accepted, 1..255
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous reset, active-high
//  seg_in       in   7        segment lines, bit0=a .. bit6=g, 1=lit
//  dp_in        in   1        decimal point line, 1=lit
//  dig_sel      in   NDIG     digit select, one-hot active-high; 0 = blanking interval
//  out_digits   out  4*NDIG   decoded nibbles, digit0 in [3:0]
//  out_blank    out  NDIG     1 = digit captured as all-segments-off
//  out_err      out  NDIG     1 = digit pattern not in glyph table (nibble reads 0)
//  out_dp       out  NDIG     captured decimal points
//  out_valid    out  1        frame available; held until accepted
//  out_ready    in   1        consumer accepts frame when out_valid&&out_ready
//  overrun      out  1        sticky: frame completed while previous frame still pending
//  sel_err      out  1        sticky: dig_sel had more than one bit set
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> SETTLE, stable counter 0, seen-mask 0, shadow regs 0.
//  - Sample reg {dig_sel,dp_in,seg_in} registered each cycle; compare against previous sample.
//  - FSM SETTLE: sample differs from previous -> counter=1; equal -> counter+1; at counter==STABLE_CYC
//    and dig_sel one-hot -> COMMIT. dig_sel==0 or multi-hot: stay SETTLE, counter held at 0;
//    multi-hot also sets sel_err.
//  - COMMIT (1 cycle): decode, write shadow slot of selected digit, set its seen bit -> LOCKED.
//  - LOCKED: stay while sample unchanged (no re-commit); any change -> SETTLE with counter=1.
//  - Glyph table (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E
//    E=79 F=71; 00 -> blank=1, nibble 0; any other -> err=1, nibble 0. Also accept 7=27, 9=67, 6=7C? no:
//    7C is always b; only 27 (7 with f) and 67 (9 without d) are alternate encodings.
//  - Re-commit of an already-seen digit overwrites its shadow slot (latest value wins).
//  - Frame complete when seen-mask all ones (evaluated the cycle after COMMIT): copy shadow -> outputs,
//    clear seen-mask, out_valid=1. Latency: last digit stable STABLE_CYC cycles -> out_valid 2 cycles later.
//  - Handshake: output regs frozen while out_valid=1 and !out_ready. Completion while out_valid&&!out_ready
//    -> frame dropped, overrun=1, seen-mask still cleared. Completion in same cycle as accept -> new frame
//    loaded, out_valid stays 1, no overrun.
//  - overrun/sel_err cleared only by rst. rst mid-frame discards shadow and seen-mask.
// CONFIGURATION
//  SEG7_DECODE_DP_EN defined: dp_in is part of the stability compare and captured into out_dp per digit.
//  Not defined: dp_in ignored (not compared, not stored), out_dp tied 0.
// TESTING
//  1 rst=1 two cycles -> all outputs 0; release, dig_sel=0 for 20 cycles -> out_valid stays 0.
//  2 scan 1,2,3,4 (06,5B,4F,66) on digits 0..3, 6 cycles each, out_ready=1 -> out_valid pulse, out_digits=16'h4321.
//  3 digit1 glitches 5B->5A for 2 cycles then 5B steady (STABLE_CYC=4) -> digit1=2, no err; pattern 0x49 -> err[1]=1.
//  4 out_ready=0, complete two frames -> first frame held, overrun=1; raise out_ready -> out_valid drops.
//  5 dig_sel=4'b0011 for 10 cycles -> sel_err=1, no commit; digit2 seg 00 -> blank[2]=1, nibble 0.
//  6 with SEG7_DECODE_DP_EN, dp_in=1 on digit3 -> out_dp=4'b1000; without macro -> out_dp=0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: receive side of a multiplexed 7-segment display bus.
// Each sample of {dig_sel, dp, seg} must repeat STABLE_CYC times before it is
// decoded into the shadow slot of the selected digit. The shadow is published
// as a frame once every digit has been seen. The frame is then held under a
// valid/ready handshake.
// Optional feature macro: SEG7_DECODE_DP_EN. When it is defined, the decimal
// point joins the stability compare and is captured per digit. When it is not
// defined, dp_in is ignored and out_dp reads 0.
module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_in,
    input  logic              dp_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] out_digits,
    output logic [NDIG-1:0]   out_blank,
    output logic [NDIG-1:0]   out_err,
    output logic [NDIG-1:0]   out_dp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              sel_err
);

    localparam int         SW     = NDIG + 8;
    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [SW-1:0]         samp_d, samp_q, prev_q;
    logic [1:0]            state_d, state_q;
    logic [7:0]            cnt_d, cnt_q;
    logic [NDIG-1:0]       seen_d, seen_q;
    logic [NDIG-1:0][3:0]  sh_nib_q;
    logic [NDIG-1:0]       sh_blank_q, sh_err_q;
    logic [NDIG-1:0]       sel_s, sel_c;
    logic                  diff, sel_ok, sel_multi, commit, done;
    logic [5:0]            dec;

    // {err, blank, nibble} for one glyph (bit0=a .. bit6=g)
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        r = 6'b000000;
        case (s)
            7'h3F: r[3:0] = 4'h0;
            7'h06: r[3:0] = 4'h1;
            7'h5B: r[3:0] = 4'h2;
            7'h4F: r[3:0] = 4'h3;
            7'h66: r[3:0] = 4'h4;
            7'h6D: r[3:0] = 4'h5;
            7'h7D: r[3:0] = 4'h6;
            7'h07: r[3:0] = 4'h7;
            7'h27: r[3:0] = 4'h7;   // 7 drawn with segment f
            7'h7F: r[3:0] = 4'h8;
            7'h6F: r[3:0] = 4'h9;
            7'h67: r[3:0] = 4'h9;   // 9 drawn without segment d
            7'h77: r[3:0] = 4'hA;
            7'h7C: r[3:0] = 4'hB;
            7'h39: r[3:0] = 4'hC;
            7'h5E: r[3:0] = 4'hD;
            7'h79: r[3:0] = 4'hE;
            7'h71: r[3:0] = 4'hF;
            7'h00: r[4]   = 1'b1;
            default: r[5] = 1'b1;
        endcase
        return r;
    endfunction

`ifdef SEG7_DECODE_DP_EN
    assign samp_d = {dig_sel, dp_in, seg_in};
`else
    logic unused_dp;
    assign unused_dp = dp_in;
    assign samp_d    = {dig_sel, 1'b0, seg_in};
`endif

    assign sel_s     = samp_q[SW-1:8];
    assign sel_c     = prev_q[SW-1:8];
    assign diff      = (samp_q != prev_q);
    assign sel_ok    = (sel_s != '0) && ((sel_s & (sel_s - NDIG'(1))) == '0);
    assign sel_multi = (sel_s != '0) && !sel_ok;
    // While in COMMIT, prev_q holds the sample that completed the stable run.
    // samp_q may already show the next change on the bus.
    assign commit    = (state_q == ST_COMMIT);
    assign dec       = decode(prev_q[6:0]);
    assign done      = &seen_q;
    assign seen_d    = (done ? '0 : seen_q) | (commit ? sel_c : '0);

    // Stability counter and SETTLE/COMMIT/LOCKED sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SETTLE: begin
                if (!sel_ok) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = diff ? 8'd1 : cnt_q + 8'd1;
                    if (cnt_d == STABLE) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT, ST_LOCKED: begin
                if (diff) begin
                    cnt_d   = sel_ok ? 8'd1 : 8'd0;
                    state_d = (sel_ok && STABLE == 8'd1) ? ST_COMMIT : ST_SETTLE;
                end else if (state_q == ST_COMMIT) begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Input sample pipeline, FSM state and seen-mask
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q  <= '0;
            prev_q  <= '0;
            state_q <= ST_SETTLE;
            cnt_q   <= 8'd0;
            seen_q  <= '0;
        end else begin
            samp_q  <= samp_d;
            prev_q  <= samp_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

`ifdef SEG7_DECODE_DP_EN
    logic [NDIG-1:0] sh_dp_q;
`endif

    // Shadow slot write on COMMIT; a repeat commit overwrites the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_nib_q   <= '0;
            sh_blank_q <= '0;
            sh_err_q   <= '0;
`ifdef SEG7_DECODE_DP_EN
            sh_dp_q    <= '0;
`endif
        end else if (commit) begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel_c[i]) begin
                    sh_nib_q[i]   <= dec[3:0];
                    sh_blank_q[i] <= dec[4];
                    sh_err_q[i]   <= dec[5];
`ifdef SEG7_DECODE_DP_EN
                    sh_dp_q[i]    <= prev_q[7];
`endif
                end
            end
        end
    end

    // Frame publish, handshake hold, sticky overrun and select-error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_digits <= '0;
            out_blank  <= '0;
            out_err    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            sel_err    <= 1'b0;
`ifdef SEG7_DECODE_DP_EN
            out_dp     <= '0;
`endif
        end else begin
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_digits <= sh_nib_q;
                    out_blank  <= sh_blank_q;
                    out_err    <= sh_err_q;
                    out_valid  <= 1'b1;
`ifdef SEG7_DECODE_DP_EN
                    out_dp     <= sh_dp_q;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (sel_multi) sel_err <= 1'b1;
        end
    end

`ifndef SEG7_DECODE_DP_EN
    assign out_dp = '0;
`endif

endmodule
